// File: rtl/adder_serial_nbit.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice and a carry flop
// walk the operands LSB first, one bit per clock, under a start/busy/done handshake.
module adder_serial_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode_sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             s_bit;
  logic             c_out;

  always_comb begin
    s_bit   = a_q[0] ^ b_q[0] ^ c_q;
    c_out   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        // Subtraction is a + ~b + 1: invert b up front and preload the carry.
        a_d     = input_a;
        b_d     = input_b ^ {WIDTH{mode_sub}};
        c_d     = mode_sub ? 1'b1 : carry_in;
        cnt_d   = '0;
        state_d = RUN;
      end
    end else begin
      a_d             = a_q >> 1;
      b_d             = b_q >> 1;
      c_d             = c_out;
      res_d           = res_q >> 1;
      res_d[WIDTH-1]  = s_bit;
      cnt_d           = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        // c_q is still the carry into the MSB here, so overflow comes for free.
        sum_d   = res_d;
        carry_d = c_out;
        ovf_d   = c_q ^ c_out;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Bench for adder_serial_nbit at WIDTH 8, 1 and 13 sharing one stimulus stream,
// each checked every cycle against an arithmetic reference with latency bookkeeping.
module tb_adder_serial_nbit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode_sub;
  logic        carry_in;
  logic [63:0] a_bus;
  logic [63:0] b_bus;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  // Returns {overflow, carry, sum} for a w-bit add or subtract.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic sub, input logic cin);
    logic [64:0] mask, aa, bb, tot, s;
    logic        cout, ovf;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    tot  = aa + bb + {64'd0, (sub ? 1'b1 : cin)};
    s    = tot & mask;
    cout = tot[w];
    ovf  = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ovf, cout, s[63:0]};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 1 : 13;

    logic [W-1:0] sum_o;
    logic         carry_o, ovf_o, busy_o, done_o;
    logic [67:0]  act, expv;
    logic [65:0]  pend;
    logic [W-1:0] m_sum;
    logic         m_carry, m_ovf, m_busy, m_done;
    int           rem;

    adder_serial_nbit #(.WIDTH(W)) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .mode_sub (mode_sub),
      .carry_in (carry_in),
      .input_a  (a_bus[W-1:0]),
      .input_b  (b_bus[W-1:0]),
      .sum      (sum_o),
      .carry    (carry_o),
      .overflow (ovf_o),
      .busy     (busy_o),
      .done     (done_o)
    );

    assign act  = {busy_o, done_o, carry_o, ovf_o, {(64-W){1'b0}}, sum_o};
    assign expv = {m_busy, m_done, m_carry, m_ovf, {(64-W){1'b0}}, m_sum};

    // Reference: result computed at accept, revealed W edges later.
    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        m_sum   <= '0;
        m_carry <= 1'b0;
        m_ovf   <= 1'b0;
        m_busy  <= 1'b0;
        m_done  <= 1'b0;
        rem     <= 0;
      end else begin
        m_done <= 1'b0;
        if (m_busy) begin
          rem <= rem - 1;
          if (rem == 1) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b1;
            m_sum   <= pend[W-1:0];
            m_carry <= pend[64];
            m_ovf   <= pend[65];
          end
        end else if (start) begin
          pend   <= ref_add(W, a_bus, b_bus, mode_sub, carry_in);
          m_busy <= 1'b1;
          rem    <= W;
        end
      end
    end
  end

  function automatic logic [67:0] lit(input logic b, input logic d, input logic c,
                                      input logic o, input logic [63:0] s);
    return {b, d, c, o, s};
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    chk("w8 cycle", g_dut[0].act, g_dut[0].expv);
    chk("w1 cycle", g_dut[1].act, g_dut[1].expv);
    chk("w13 cycle", g_dut[2].act, g_dut[2].expv);
  endtask

  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic sub,
                       input logic cin, input logic st);
    a_bus    = a;
    b_bus    = b;
    mode_sub = sub;
    carry_in = cin;
    start    = st;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!g_dut[0].done_o && lat < 40);
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic sub, input logic cin, input logic [67:0] exp);
    int lat;
    apply({56'd0, a}, {56'd0, b}, sub, cin, 1'b1);
    tick();
    start = 1'b0;
    wait_done(lat);
    chk({name, " latency"}, 68'(lat), 68'd8);
    chk({name, " dut"}, g_dut[0].act, exp);
    chk({name, " model"}, g_dut[0].expv, exp);
  endtask

  initial begin
    int lat;
    int ndone;
    int n13;
    int cyc;

    reset_n = 1'b0;
    apply(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("reset w8", g_dut[0].act, 68'd0);
    chk("reset w1", g_dut[1].act, 68'd0);
    chk("reset w13", g_dut[2].act, 68'd0);
    reset_n = 1'b1;
    tick();

    run8("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, lit(1'b0, 1'b1, 1'b1, 1'b0, 64'h00));
    run8("7f+01+1", 8'h7F, 8'h01, 1'b0, 1'b1, lit(1'b0, 1'b1, 1'b0, 1'b1, 64'h81));
    run8("05-07", 8'h05, 8'h07, 1'b1, 1'b0, lit(1'b0, 1'b1, 1'b0, 1'b0, 64'hFE));
    run8("80-01", 8'h80, 8'h01, 1'b1, 1'b0, lit(1'b0, 1'b1, 1'b1, 1'b1, 64'h7F));
    tick();
    chk("done one cycle", 68'(g_dut[0].done_o), 68'd0);

    // Starts while busy with different operands must be ignored.
    apply(64'h10, 64'h20, 1'b0, 1'b0, 1'b1);
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) apply(64'h55, 64'hAA, 1'b1, 1'b1, 1'b1);
      else if (c == 4) apply(64'h66, 64'h77, 1'b0, 1'b1, 1'b1);
      else start = 1'b0;
      tick();
    end
    chk("busy start ignored", g_dut[0].act, lit(1'b0, 1'b1, 1'b0, 1'b0, 64'h30));

    // Start accepted in the done cycle, no idle gap.
    apply(64'h03, 64'h04, 1'b0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    chk("b2b busy not done", 68'({g_dut[0].busy_o, g_dut[0].done_o}), 68'b10);
    wait_done(lat);
    chk("b2b latency", 68'(lat), 68'd8);
    chk("b2b result", g_dut[0].act, lit(1'b0, 1'b1, 1'b0, 1'b0, 64'h07));

    // Reset in the middle of an op.
    apply(64'h12, 64'h34, 1'b0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("async reset w8", g_dut[0].act, 68'd0);
    chk("async reset w1", g_dut[1].act, 68'd0);
    chk("async reset w13", g_dut[2].act, 68'd0);
    tick();
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (g_dut[0].done_o) ndone++;
    end
    chk("no done after abort", 68'(ndone), 68'd0);

    // WIDTH=1 completes one edge after accept; W=8 runs 01+01 alongside.
    apply(64'd1, 64'd1, 1'b0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    tick();
    chk("w1 1+1", g_dut[1].act, lit(1'b0, 1'b1, 1'b1, 1'b1, 64'h0));
    wait_done(lat);
    chk("01+01 latency", 68'(lat), 68'd7);
    chk("01+01 result", g_dut[0].act, lit(1'b0, 1'b1, 1'b0, 1'b0, 64'h02));
    run8("22+11 after reset", 8'h22, 8'h11, 1'b0, 1'b0, lit(1'b0, 1'b1, 1'b0, 1'b0, 64'h33));

    // Random sweep until the 13-bit instance has completed 1000 ops.
    n13 = 0;
    cyc = 0;
    while (n13 < 1000 && cyc < 40000) begin
      apply({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(3) != 0));
      tick();
      cyc++;
      if (g_dut[2].done_o) n13++;
    end
    chk("w13 op count", 68'(n13), 68'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
